regfile_sb: RTL

- Parametrised, clocked successor to the decode-stage register file.
- Provides two registered read ports (A, B) and one synchronous write port, with optional write-to-read bypass and optional hard-wired zero register.
- Adds a per-register pending-write scoreboard: issue marks a destination busy, writeback clears it, and `stall` flags reads of busy sources.
- Sits in the decode stage, between fetch/issue control and the writeback path.

---
 rtl/regfile_sb_if.sv | 32 +++
 rtl/regfile_sb.sv | 78 +++++++
 2 files changed

// File: rtl/regfile_sb_if.sv
// Decode-stage register file bus: read ports, writeback port, issue port and
// scoreboard status, bundled for the register file and its driver.
interface regfile_sb_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rt;
   logic [ADDR_W-1:0] rd;
   logic [WIDTH-1:0]  writedata;
   logic              regwrite;
   logic              issue;
   logic [ADDR_W-1:0] issue_rd;
   logic [WIDTH-1:0]  A;
   logic [WIDTH-1:0]  B;
   logic              stall;
   logic [DEPTH-1:0]  busy_vec;

   // issue/stall contract: the issuer holds back any instruction whose sources
   // raise stall; the register file never refuses a write or an issue itself.
   modport master (
      output rs, rt, rd, writedata, regwrite, issue, issue_rd,
      input  A, B, stall, busy_vec
   );

   modport slave (
      input  rs, rt, rd, writedata, regwrite, issue, issue_rd,
      output A, B, stall, busy_vec
   );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two registered read ports, one write port, optional
// write-to-read bypass / hard-wired zero register and a pending-write scoreboard.
module regfile_sb #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic         clk,
   input logic         rst,
   regfile_sb_if.slave bus
);
   localparam int DEPTH    = 2 ** ADDR_W;
   localparam bit HAS_ZERO = (ZERO_REG != 0);
   localparam bit HAS_BYP  = (BYPASS != 0);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;
   logic [WIDTH-1:0] val_a;
   logic [WIDTH-1:0] val_b;
   logic             wr_en;
   logic             fwd_a;
   logic             fwd_b;

   always_comb begin
      wr_en = bus.regwrite && !(HAS_ZERO && bus.rd == '0);
      fwd_a = HAS_BYP && bus.regwrite && (bus.rd == bus.rs);
      fwd_b = HAS_BYP && bus.regwrite && (bus.rd == bus.rt);
   end

   // Zero register has priority over the bypass path.
   always_comb begin
      val_a = fwd_a ? bus.writedata : regs[bus.rs];
      val_b = fwd_b ? bus.writedata : regs[bus.rt];
      if (HAS_ZERO && bus.rs == '0) val_a = '0;
      if (HAS_ZERO && bus.rt == '0) val_b = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[bus.rd] <= bus.writedata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.A <= '0;
         bus.B <= '0;
      end else begin
         bus.A <= val_a;
         bus.B <= val_b;
      end
   end

   // Set after clear: a newly issued producer owns the register even when
   // the previous producer writes back in the same cycle.
   always_comb begin
      busy_d = busy_q;
      if (bus.regwrite) busy_d[bus.rd] = 1'b0;
      if (bus.issue) busy_d[bus.issue_rd] = 1'b1;
      if (HAS_ZERO) busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   // A source being written back this cycle is forwarded, so it need not stall.
   always_comb begin
      bus.stall = (busy_q[bus.rs] & ~fwd_a) | (busy_q[bus.rt] & ~fwd_b);
   end

   assign bus.busy_vec = busy_q;
endmodule
